// File: rtl/core_ctrl_pkg.sv
// Shared types and default widths for the core run controller and its helpers.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam int DEF_CW = 16;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Memory-side bundle of the run controller: host port, core port and data_mem port.
interface core_run_ctrl_if
    import core_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;

    logic          core_mem_read;
    logic          core_mem_write;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // The controller is the slave of host/core requests and drives data_mem.
    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata,
        input  core_mem_read, core_mem_write, core_addr, core_wdata,
        output core_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata,
        output core_mem_read, core_mem_write, core_addr, core_wdata,
        input  core_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/run_cycle_counter.sv
// Saturating RUN-cycle counter with synchronous clear and an equality compare tap.
module run_cycle_counter
    import core_ctrl_pkg::*;
#(
    parameter int CW     = DEF_CW,
    parameter bit CMP_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] cmp_value,
    output logic [CW-1:0] count,
    output logic          cmp_hit
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    // Compare folds away entirely when the watchdog is not built in.
    assign cmp_hit = CMP_EN && (count_q == cmp_value);

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller and data-memory arbiter for the 9-bit-instruction core.
// Optional watchdog forced stop is compiled in with `define CORE_RUN_WATCHDOG_EN.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int          AW         = DEF_AW,
    parameter int          DW         = DEF_DW,
    parameter int          CW         = DEF_CW,
    parameter int unsigned WDOG_LIMIT = 4095
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          core_halt,
    output logic          core_reset,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    core_run_ctrl_if.slave bus
);

`ifdef CORE_RUN_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    run_state_t state_q, state_d;
    logic       done_q, done_d;
    logic       timeout_q, timeout_d;
    logic       cnt_clr;
    logic       wdog_hit;

    run_cycle_counter #(
        .CW     (CW),
        .CMP_EN (WDOG_EN)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (state_q == RUN),
        .cmp_value (CW'(WDOG_LIMIT - 1)),
        .count     (cycle_count),
        .cmp_hit   (wdog_hit)
    );

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = ARM;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            ARM: begin
                state_d = RUN;
            end
            RUN: begin
                // Halt takes priority over a simultaneous watchdog expiry.
                if (core_halt) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (wdog_hit) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    logic          mux_host_gnt;
    logic [DW-1:0] mux_host_rdata;
    logic [DW-1:0] mux_core_rdata;
    logic          mux_mem_read;
    logic          mux_mem_write;
    logic [AW-1:0] mux_mem_addr;
    logic [DW-1:0] mux_mem_wdata;

    always_comb begin
        mux_host_gnt   = 1'b0;
        mux_host_rdata = '0;
        mux_core_rdata = '0;
        mux_mem_read   = 1'b0;
        mux_mem_write  = 1'b0;
        mux_mem_addr   = bus.host_addr;
        mux_mem_wdata  = bus.host_wdata;
        case (state_q)
            IDLE, DONE: begin
                mux_host_gnt   = bus.host_req;
                mux_mem_read   = bus.host_req & ~bus.host_we;
                mux_mem_write  = bus.host_req & bus.host_we;
                mux_host_rdata = bus.host_req ? bus.mem_rdata : '0;
            end
            RUN: begin
                mux_mem_read   = bus.core_mem_read;
                mux_mem_write  = bus.core_mem_write;
                mux_mem_addr   = bus.core_addr;
                mux_mem_wdata  = bus.core_wdata;
                mux_core_rdata = bus.mem_rdata;
            end
            default: ;
        endcase
        // Reset must silence the memory immediately, even mid-RUN before state_q moves.
        if (reset) begin
            mux_host_gnt   = 1'b0;
            mux_mem_read   = 1'b0;
            mux_mem_write  = 1'b0;
            mux_host_rdata = '0;
            mux_core_rdata = '0;
        end
    end

    assign bus.host_gnt   = mux_host_gnt;
    assign bus.host_rdata = mux_host_rdata;
    assign bus.core_rdata = mux_core_rdata;
    assign bus.mem_read   = mux_mem_read;
    assign bus.mem_write  = mux_mem_write;
    assign bus.mem_addr   = mux_mem_addr;
    assign bus.mem_wdata  = mux_mem_wdata;

    assign core_reset = reset | (state_q != RUN);
    assign done       = done_q;
    assign timeout    = WDOG_EN ? timeout_q : 1'b0;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: preload, run/halt, arbitration, mid-run reset,
// watchdog (or no-stop behaviour without it) and restart, with a read-data scoreboard.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        core_halt;
    logic        core_reset;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    int tests = 0;
    int fails = 0;
    int wr_in_reset = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mem [256];

    core_run_ctrl_if #(.AW(8), .DW(8)) bus ();

    core_run_ctrl #(
        .AW         (8),
        .DW         (8),
        .CW         (16),
        .WDOG_LIMIT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_halt   (core_halt),
        .core_reset  (core_reset),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // data_mem model: combinational read, write at the edge ending the cycle
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_write && reset) wr_in_reset <= wr_in_reset + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=0x%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(obs), 32'(e));
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        reset = 1'b1; start = 1'b0; core_halt = 1'b0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.core_mem_read = 1'b0; bus.core_mem_write = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;

        // ---- reset: memory and grant forced off while reset is high
        step();
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h33; bus.host_wdata = 8'h99;
        sample();
        check("rst_host_gnt", 32'(bus.host_gnt), 0);
        check("rst_mem_write", 32'(bus.mem_write), 0);
        check("rst_mem_read", 32'(bus.mem_read), 0);
        check("rst_core_reset", 32'(core_reset), 1);
        step();
        reset = 1'b0; bus.host_req = 1'b0; bus.host_we = 1'b0;
        sample();
        check("init_done", 32'(done), 0);
        check("init_timeout", 32'(timeout), 0);
        check("init_cycle_count", 32'(cycle_count), 0);
        check("init_core_reset", 32'(core_reset), 1);
        check("init_host_rdata", 32'(bus.host_rdata), 0);
        check("init_core_rdata", 32'(bus.core_rdata), 0);

        // ---- preload write then read back
        step();
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h10; bus.host_wdata = 8'h5A;
        $display("[TB] txn host write addr=0x10 data=0x5a");
        sample();
        check("pre_wr_gnt", 32'(bus.host_gnt), 1);
        check("pre_wr_mem_write", 32'(bus.mem_write), 1);
        check("pre_wr_core_reset", 32'(core_reset), 1);
        step();
        bus.host_we = 1'b0;
        exp_q.push_back(8'h5A);
        $display("[TB] txn host read addr=0x10");
        sample();
        check("pre_rd_gnt", 32'(bus.host_gnt), 1);
        check("pre_rd_mem_read", 32'(bus.mem_read), 1);
        check("pre_rd_core_reset", 32'(core_reset), 1);
        sb_check("pre_rd_host_rdata", bus.host_rdata);
        step();
        bus.host_req = 1'b0;
        sample();
        check("nogrant_host_rdata", 32'(bus.host_rdata), 0);

        // ---- run with halt in RUN cycle 5, host waiting on 0x20 meanwhile
        step();
        start = 1'b1;
        $display("[TB] txn start");
        sample();
        check("start_core_reset", 32'(core_reset), 1);
        step();
        start = 1'b0;
        bus.core_mem_read = 1'b1; bus.core_addr = 8'h10;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h20;
        sample();
        check("arm_core_reset", 32'(core_reset), 1);
        check("arm_host_gnt", 32'(bus.host_gnt), 0);
        check("arm_mem_read", 32'(bus.mem_read), 0);
        check("arm_done", 32'(done), 0);
        check("arm_cycle_count", 32'(cycle_count), 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            bus.core_mem_read  = (i != 3);
            bus.core_mem_write = (i == 3);
            bus.core_addr      = (i == 3) ? 8'h20 : 8'h10;
            bus.core_wdata     = 8'hC3;
            core_halt          = (i == 5);
            if (i != 3) exp_q.push_back(8'h5A);
            $display("[TB] txn run cycle %0d core %s addr=0x%0h", i, (i == 3) ? "write" : "read", bus.core_addr);
            sample();
            check("run_core_reset", 32'(core_reset), 0);
            check("run_host_gnt", 32'(bus.host_gnt), 0);
            check("run_host_rdata", 32'(bus.host_rdata), 0);
            check("run_mem_addr", 32'(bus.mem_addr), (i == 3) ? 32'h20 : 32'h10);
            check("run_cycle_count", 32'(cycle_count), 32'(i - 1));
            if (i == 3) check("run_mem_write", 32'(bus.mem_write), 1);
            else sb_check("run_core_rdata", bus.core_rdata);
        end
        step();
        core_halt = 1'b0; bus.core_mem_read = 1'b0; bus.core_mem_write = 1'b0;
        exp_q.push_back(8'hC3);
        $display("[TB] txn host read addr=0x20 (first DONE cycle)");
        sample();
        check("halt_done", 32'(done), 1);
        check("halt_timeout", 32'(timeout), 0);
        check("halt_cycle_count", 32'(cycle_count), 5);
        check("halt_core_reset", 32'(core_reset), 1);
        check("halt_host_gnt", 32'(bus.host_gnt), 1);
        check("halt_core_rdata", 32'(bus.core_rdata), 0);
        sb_check("halt_host_rdata", bus.host_rdata);
        step();
        bus.host_req = 1'b0; core_halt = 1'b1;
        sample();
        check("done_frozen_count", 32'(cycle_count), 5);
        check("done_held", 32'(done), 1);
        step();
        core_halt = 1'b0;

        // ---- restart, then reset in RUN cycle 3
        start = 1'b1;
        $display("[TB] txn restart");
        sample();
        check("restart_done_pre", 32'(done), 1);
        step();
        start = 1'b0;
        sample();
        check("restart_arm_done", 32'(done), 0);
        check("restart_arm_timeout", 32'(timeout), 0);
        check("restart_arm_count", 32'(cycle_count), 0);
        for (int i = 1; i <= 2; i++) begin
            step();
            sample();
            check("restart_core_reset", 32'(core_reset), 0);
            check("restart_count", 32'(cycle_count), 32'(i - 1));
        end
        step();
        reset = 1'b1;
        bus.core_mem_write = 1'b1; bus.core_addr = 8'h40; bus.core_wdata = 8'hEE;
        $display("[TB] txn reset in RUN cycle 3 with core write addr=0x40");
        sample();
        check("midrst_mem_write", 32'(bus.mem_write), 0);
        check("midrst_core_reset", 32'(core_reset), 1);
        check("midrst_host_gnt", 32'(bus.host_gnt), 0);
        step();
        reset = 1'b0; bus.core_mem_write = 1'b0;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h40;
        exp_q.push_back(8'h00);
        $display("[TB] txn host read addr=0x40 after reset");
        sample();
        check("postrst_count", 32'(cycle_count), 0);
        check("postrst_core_reset", 32'(core_reset), 1);
        check("postrst_done", 32'(done), 0);
        check("postrst_idle_gnt", 32'(bus.host_gnt), 1);
        check("postrst_no_write", 32'(wr_in_reset), 0);
        sb_check("postrst_host_rdata", bus.host_rdata);
        step();
        bus.host_req = 1'b0;

        // ---- run without halt
        start = 1'b1;
        $display("[TB] txn start (no halt)");
        step();
        start = 1'b0;
        step();
`ifdef CORE_RUN_WATCHDOG_EN
        for (int i = 1; i <= 8; i++) begin
            sample();
            check("wdog_run_done", 32'(done), 0);
            check("wdog_run_core_reset", 32'(core_reset), 0);
            step();
        end
        sample();
        check("wdog_done", 32'(done), 1);
        check("wdog_timeout", 32'(timeout), 1);
        check("wdog_count", 32'(cycle_count), 8);
        check("wdog_core_reset", 32'(core_reset), 1);
        step();
        start = 1'b1;
        $display("[TB] txn restart after watchdog");
        step();
        start = 1'b0;
        sample();
        check("wdog_arm_timeout", 32'(timeout), 0);
        check("wdog_arm_done", 32'(done), 0);
        step();
        for (int i = 1; i <= 8; i++) begin
            core_halt = (i == 8);
            sample();
            check("wdog2_run_done", 32'(done), 0);
            step();
        end
        core_halt = 1'b0;
        sample();
        check("wdog_halt_done", 32'(done), 1);
        check("wdog_halt_timeout", 32'(timeout), 0);
        check("wdog_halt_count", 32'(cycle_count), 8);
`else
        for (int i = 1; i <= 12; i++) begin
            sample();
            check("free_run_done", 32'(done), 0);
            check("free_run_timeout", 32'(timeout), 0);
            step();
        end
        core_halt = 1'b1;
        sample();
        step();
        core_halt = 1'b0;
        sample();
        check("free_halt_done", 32'(done), 1);
        check("free_halt_timeout", 32'(timeout), 0);
        check("free_halt_count", 32'(cycle_count), 13);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run controller and data-memory arbiter for the 9-bit-instruction CPU core. It holds the core in reset while a host (testbench or loader) preloads or reads back data memory, then releases the core on `start`. It counts execution cycles and detects the decoder's Halt. It returns memory ownership to the host and reports `done`, plus optional watchdog `timeout`. It sits between the core datapath's memory port and `data_mem`, and drives the core's reset.

## Interface
- `AW`, 8, data-memory address width
- `DW`, 8, data-memory data width
- `CW`, 16, cycle-counter width
- `WDOG_LIMIT`, 16'd4095, RUN-cycle limit before forced stop (used only with watchdog compiled in)

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `start` in 1: host request to begin execution
- `host_req` in 1; `host_we` in 1; `host_addr` in AW; `host_wdata` in DW: host memory access
- `host_gnt` out 1; `host_rdata` out DW: host grant / read data
- `core_mem_read` in 1; `core_mem_write` in 1; `core_addr` in AW; `core_wdata` in DW: core memory access
- `core_rdata` out DW: read data to core
- `mem_read` out 1; `mem_write` out 1; `mem_addr` out AW; `mem_wdata` out DW: to `data_mem`
- `mem_rdata` in DW: from `data_mem` (combinational read)
- `core_halt` in 1: decoder Halt
- `core_reset` out 1: holds core (PC) in reset
- `done` out 1; `timeout` out 1; `cycle_count` out CW: status

## Operation
- FSM states:
  - IDLE: host owns memory; `core_reset`=1.
  - ARM: one cycle; `core_reset`=1; counter cleared; `done`/`timeout` cleared.
  - RUN: core owns memory; `core_reset`=0; counter increments each cycle.
  - DONE: host owns memory; `core_reset`=1; `done`=1.
- Transitions:
  - IDLE -> ARM on `start`.
  - ARM -> RUN unconditionally.
  - RUN -> DONE on `core_halt`, or on watchdog expiry.
  - DONE -> ARM on `start`.
  - `start` is ignored in ARM and RUN.
- Memory ownership:
  - Host phases (IDLE, DONE):
    - `host_gnt` = `host_req`.
    - `mem_read` = `host_req & ~host_we`; `mem_write` = `host_req & host_we`.
    - `mem_addr`/`mem_wdata` come from host.
    - `host_rdata` = `mem_rdata` when granted, else 0.
    - `core_rdata` = 0.
  - RUN:
    - `host_gnt` = 0; host must hold `host_req` until granted.
    - Core signals pass straight through to `mem_*`.
    - `core_rdata` = `mem_rdata`; `host_rdata` = 0.
  - ARM: `mem_read`/`mem_write` = 0; `host_gnt` = 0.
- `cycle_count` counts RUN cycles, including the halting cycle. It is frozen in DONE and saturates at all-ones.
- `core_halt` is ignored outside RUN.
- Reset (any state, including mid-RUN): next state IDLE; counter, `done` and `timeout` cleared. While `reset`=1, `host_gnt`, `mem_read` and `mem_write` are forced to 0 and `core_reset`=1.

## Timing
- Reset values: `done`=0, `timeout`=0, `cycle_count`=0, `core_reset`=1, `host_gnt`=0, `mem_read`=0, `mem_write`=0, `host_rdata`=0, `core_rdata`=0.
- `start` sampled at edge N in IDLE gives ARM in cycle N+1 and RUN in cycle N+2, with `core_reset` low from N+2. The core fetches PC=0 in the first RUN cycle.
- `core_halt`=1 in RUN cycle K gives DONE and `done`=1 from cycle K+1. `cycle_count` = K - (first RUN cycle) + 1.
- Host writes commit at the edge ending the granted cycle. Host reads return data in the same cycle.
- Halt and watchdog expiry in the same cycle: halt wins and `timeout`=0.

## Configuration
- `CORE_RUN_WATCHDOG_EN` defined:
  - In RUN, when `cycle_count` == `WDOG_LIMIT`-1 and `core_halt`=0, the next state is DONE with `timeout`=1.
  - `timeout` is held until ARM or reset.
- Undefined: no forced stop; `timeout` is tied to 0 and `WDOG_LIMIT` is unused.

## Structure
- Shared package `core_ctrl_pkg`:
  - `run_state_t` enum (IDLE, ARM, RUN, DONE).
  - Default width constants matching `AW`/`DW`/`CW`.
- Sub-module `run_cycle_counter`:
  - Clear, enable, saturating count.
  - Limit-compare output, used by the watchdog.
- The FSM and the memory mux live in `core_run_ctrl`.

## Test plan
- Preload: in IDLE, write 8'h5A to addr 8'h10, then read it back. Required: `host_gnt`=1 in both cycles; `host_rdata`=8'h5A; `core_reset`=1 throughout.
- Run/halt: pulse `start`, then drive `core_halt`=1 in the 5th RUN cycle. Required: `core_reset` falls 2 cycles after `start`; `done`=1 one cycle after halt; `cycle_count`=5.
- Arbitration: host requests addr 8'h20 during RUN. Required: `host_gnt`=0 and the core's address reaches `mem_addr`; the grant is given in the first DONE cycle.
- Reset mid-RUN: assert `reset` in RUN cycle 3. Required: state IDLE next cycle; `cycle_count`=0; `core_reset`=1; no memory write issued while `reset`=1.
- Watchdog (macro on, `WDOG_LIMIT`=8, no halt): required `done`=1, `timeout`=1, `cycle_count`=8. Halt in cycle 8: required `timeout`=0.
- Restart: `start` in DONE. Required: `done` and `timeout` cleared in ARM; `cycle_count` restarts from 0.
